// File: rtl/mem_arbiter.sv
// mem_arbiter
// ---------------------------------------------------------------------------
// Shares the single physical-memory port between the LC-3b instruction cache
// (read-only) and data cache (read/write). One transaction is in flight at a
// time; when both caches contend, the side that was not served last wins.
// Each side also has a completed-transaction counter for the performance TRAP.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   i_read, i_address   I-cache line read request (level) and address
//   i_rdata, i_resp     line data and completion pulse back to the I-cache
//   d_read, d_write     D-cache line read / write-back requests (level)
//   d_address, d_wdata  D-cache line address and write-back data
//   d_rdata, d_resp     line data and completion pulse back to the D-cache
//   pmem_*              memory/L2 side: read/write strobes, address, data,
//                       read data and completion
//   reset_counters      clears both transaction counters
//   i_count, d_count    completed I-side / D-side transactions (wrapping)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    input  logic              reset_counters,
    output logic [CNT_W-1:0]  i_count,
    output logic [CNT_W-1:0]  d_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t state;
    state_t next_state;
    grant_t last_grant;

    logic i_pending;
    logic d_pending;
    logic i_done;
    logic d_done;

    assign i_pending = i_read;
    assign d_pending = d_read | d_write;

    // A transaction only completes while it is actually being served, so a
    // stray pmem_resp in IDLE can never move the FSM or a counter.
    assign i_done = (state == SERVE_I) && pmem_resp;
    assign d_done = (state == SERVE_D) && pmem_resp;

    // Read data is broadcast to both caches; each qualifies it with its resp.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // State register and round-robin history. last_grant resets to D so the
    // I-cache wins the very first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state <= next_state;
            if (i_done) begin
                last_grant <= GRANT_I;
            end else if (d_done) begin
                last_grant <= GRANT_D;
            end
        end
    end

    // Next-state and output decode. The grant is only decided in IDLE, which
    // also guarantees one dead cycle between consecutive transactions. In
    // SERVE_D a write-back takes precedence over a read so the two memory
    // strobes are never high together.
    always_comb begin
        next_state   = state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;

        case (state)
            IDLE: begin
                if (i_pending && d_pending) begin
                    next_state = (last_grant == GRANT_D) ? SERVE_I : SERVE_D;
                end else if (i_pending) begin
                    next_state = SERVE_I;
                end else if (d_pending) begin
                    next_state = SERVE_D;
                end
            end
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                i_resp       = pmem_resp;
                if (pmem_resp) begin
                    next_state = IDLE;
                end
            end
            SERVE_D: begin
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                if (d_write) begin
                    pmem_write = 1'b1;
                end else begin
                    pmem_read = 1'b1;
                end
                d_resp = pmem_resp;
                if (pmem_resp) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Per-side completion counters. Both reset and reset_counters override a
    // same-edge increment; the counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset || reset_counters) begin
            i_count <= '0;
            d_count <= '0;
        end else begin
            if (i_done) begin
                i_count <= i_count + CNT_W'(1);
            end
            if (d_done) begin
                d_count <= d_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// ---------------------------------------------------------------------------
// Self-checking bench for mem_arbiter. A table of per-cycle input/expected
// output records covers the single-requester, write-back, contention-during-
// service, stray-response and reset-mid-transaction cases. Hand-written
// sequences then cover round-robin ordering (with a grant-order scoreboard)
// and counter wrap / reset_counters priority. The counter is instantiated
// narrow so that the wrap case needs only a few hundred transactions.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 8;

    localparam logic [ADDR_W-1:0] I_ADDR = 16'h1230;
    localparam logic [ADDR_W-1:0] D_ADDR = 16'h4000;
    localparam logic [LINE_W-1:0] RDATA  = {16{8'hA5}};
    localparam logic [LINE_W-1:0] WDATA  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    logic              clk;
    logic              reset;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              reset_counters;
    logic [CNT_W-1:0]  i_count;
    logic [CNT_W-1:0]  d_count;

    int checks;
    int passes;

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .LINE_W(LINE_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_rdata       (i_rdata),
        .i_resp        (i_resp),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_resp        (d_resp),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_address  (pmem_address),
        .pmem_wdata    (pmem_wdata),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp),
        .reset_counters(reset_counters),
        .i_count       (i_count),
        .d_count       (d_count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence loses track of the DUT.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        logic             rst;
        logic             ird;
        logic             drd;
        logic             dwr;
        logic             presp;
        logic             rcnt;
        logic             chk;
        logic             e_pread;
        logic             e_pwrite;
        logic             e_iresp;
        logic             e_dresp;
        logic [ADDR_W-1:0] e_addr;
        logic [CNT_W-1:0] e_icnt;
        logic [CNT_W-1:0] e_dcnt;
    } vec_t;

    vec_t vecs[$];
    byte  grant_q[$];

    function automatic vec_t mk(input logic rst, input logic ird, input logic drd,
                                input logic dwr, input logic presp, input logic rcnt,
                                input logic chk, input logic pr, input logic pw,
                                input logic ir, input logic dr,
                                input logic [ADDR_W-1:0] addr,
                                input int ic, input int dc);
        vec_t v;
        v.rst      = rst;
        v.ird      = ird;
        v.drd      = drd;
        v.dwr      = dwr;
        v.presp    = presp;
        v.rcnt     = rcnt;
        v.chk      = chk;
        v.e_pread  = pr;
        v.e_pwrite = pw;
        v.e_iresp  = ir;
        v.e_dresp  = dr;
        v.e_addr   = addr;
        v.e_icnt   = CNT_W'(ic);
        v.e_dcnt   = CNT_W'(dc);
        return v;
    endfunction

    task automatic drive(input logic rst, input logic ird, input logic drd,
                         input logic dwr, input logic presp, input logic rcnt);
        reset          = rst;
        i_read         = ird;
        d_read         = drd;
        d_write        = dwr;
        pmem_resp      = presp;
        reset_counters = rcnt;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.rst, v.ird, v.drd, v.dwr, v.presp, v.rcnt);
    endtask

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] actual,
                               input logic [LINE_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end else begin
            passes++;
        end
    endtask

    // Compares every output the record constrains; data/address fields are
    // only meaningful while the matching strobe or resp is expected.
    task automatic checkVector(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        checkOutput({tag, "_pmem_read"},  LINE_W'(pmem_read),  LINE_W'(v.e_pread));
        checkOutput({tag, "_pmem_write"}, LINE_W'(pmem_write), LINE_W'(v.e_pwrite));
        checkOutput({tag, "_i_resp"},     LINE_W'(i_resp),     LINE_W'(v.e_iresp));
        checkOutput({tag, "_d_resp"},     LINE_W'(d_resp),     LINE_W'(v.e_dresp));
        checkOutput({tag, "_i_count"},    LINE_W'(i_count),    LINE_W'(v.e_icnt));
        checkOutput({tag, "_d_count"},    LINE_W'(d_count),    LINE_W'(v.e_dcnt));
        if (v.e_pread || v.e_pwrite) begin
            checkOutput({tag, "_pmem_address"}, LINE_W'(pmem_address), LINE_W'(v.e_addr));
        end
        if (v.e_pwrite) begin
            checkOutput({tag, "_pmem_wdata"}, pmem_wdata, WDATA);
        end
        if (v.e_iresp) begin
            checkOutput({tag, "_i_rdata"}, i_rdata, RDATA);
        end
        if (v.e_dresp) begin
            checkOutput({tag, "_d_rdata"}, d_rdata, RDATA);
        end
    endtask

    initial begin
        int  completions;
        int  serve_len;
        int  budget;
        logic prev_strobe;
        logic prev_resp;
        logic strobe;
        byte side;
        byte exp_side;

        checks         = 0;
        passes         = 0;
        i_address      = I_ADDR;
        d_address      = D_ADDR;
        d_wdata        = WDATA;
        pmem_rdata     = RDATA;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //        rst ird drd dwr rsp rcn chk  pr  pw  ir  dr  addr    ic dc
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  '0,     0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1,  1,  0,  0,  0,  I_ADDR, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1,  1,  0,  0,  0,  I_ADDR, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0,  1,  1,  0,  1,  0,  I_ADDR, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     1, 0));
        // write-back, then write-back with read also raised
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  1,  0,  0,  0,  0,  '0,     1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,  1,  0,  1,  0,  0,  D_ADDR, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0,  1,  0,  1,  0,  1,  D_ADDR, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1,  0,  0,  0,  0,  '0,     1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,  1,  0,  1,  0,  0,  D_ADDR, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0,  1,  0,  1,  0,  1,  D_ADDR, 1, 1));
        // D read with I raised mid-service; I must wait, then win next
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     1, 2));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  1,  1,  0,  0,  0,  D_ADDR, 1, 2));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,  1,  1,  0,  0,  0,  D_ADDR, 1, 2));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0,  1,  1,  0,  0,  1,  D_ADDR, 1, 2));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     1, 3));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0,  1,  1,  0,  0,  0,  I_ADDR, 1, 3));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0,  1,  1,  0,  1,  0,  I_ADDR, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     2, 3));
        // stray pmem_resp while idle
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1,  0,  0,  0,  0,  '0,     2, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     2, 3));
        // reset in the middle of an I transaction, then a late pmem_resp
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     2, 3));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,  1,  1,  0,  0,  0,  I_ADDR, 2, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,  1,  0,  0,  0,  0,  '0,     0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0,  '0,     0, 0));

        // Table-driven section: inputs change on the falling edge, outputs
        // are sampled 2 ns later, well before the next rising edge.
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            if (vecs[i].chk) begin
                checkVector(i, vecs[i]);
            end
        end

        // Round-robin: both caches request from reset and hold their
        // requests. The memory answers on the second strobe cycle. The
        // expected grant order is queued as the requests are raised.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        grant_q.push_back("I");
        grant_q.push_back("D");
        grant_q.push_back("I");
        grant_q.push_back("D");
        completions = 0;
        serve_len   = 0;
        prev_strobe = 1'b0;
        prev_resp   = 1'b0;
        budget      = 0;
        while (completions < 4 && budget < 60) begin
            if (budget > 0) begin
                @(negedge clk);
            end
            pmem_resp = (serve_len == 1);
            #2;
            strobe = pmem_read | pmem_write;
            side   = (pmem_address == I_ADDR) ? "I" : "D";
            if (prev_resp) begin
                checkOutput("rr_turnaround_idle", LINE_W'(strobe), LINE_W'(1'b0));
            end
            if (strobe && !prev_strobe) begin
                if (grant_q.size() == 0) begin
                    checkOutput("rr_unexpected_grant", LINE_W'(side), LINE_W'(8'h00));
                end else begin
                    exp_side = grant_q.pop_front();
                    checkOutput("rr_grant_order", LINE_W'(side), LINE_W'(exp_side));
                end
            end
            if (strobe && pmem_resp) begin
                checkOutput("rr_i_resp", LINE_W'(i_resp), LINE_W'(side == "I"));
                checkOutput("rr_d_resp", LINE_W'(d_resp), LINE_W'(side == "D"));
                completions++;
            end
            prev_resp   = strobe && pmem_resp;
            prev_strobe = strobe;
            serve_len   = strobe ? serve_len + 1 : 0;
            budget++;
        end
        checkOutput("rr_completions", LINE_W'(completions), LINE_W'(4));
        checkOutput("rr_grants_left", LINE_W'(grant_q.size()), LINE_W'(0));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("rr_i_count", LINE_W'(i_count), LINE_W'(2));
        checkOutput("rr_d_count", LINE_W'(d_count), LINE_W'(2));

        // Counter wrap: drive the I counter to its maximum with back-to-back
        // single-cycle transactions, then one more must wrap it to zero.
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        completions = 0;
        budget      = 0;
        while (completions < int'(CNT_MAX) && budget < 4 * int'(CNT_MAX) + 10) begin
            #2;
            if (i_resp) begin
                completions++;
            end
            budget++;
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("wrap_completions", LINE_W'(completions), LINE_W'(CNT_MAX));
        checkOutput("wrap_i_count_max", LINE_W'(i_count), LINE_W'(CNT_MAX));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        checkOutput("wrap_i_resp", LINE_W'(i_resp), LINE_W'(1'b1));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("wrap_i_count_zero", LINE_W'(i_count), LINE_W'(0));

        // One D transaction so both counters are non-zero, then an I
        // completion with reset_counters on the same edge.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("rc_d_count_before", LINE_W'(d_count), LINE_W'(1));
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        checkOutput("rc_i_resp", LINE_W'(i_resp), LINE_W'(1'b1));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("rc_i_count", LINE_W'(i_count), LINE_W'(0));
        checkOutput("rc_d_count", LINE_W'(d_count), LINE_W'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
